// File: rtl/spi_tx_pkg.sv
// Shared types and helpers for the multi-lane SPI master transmit shifter.
package spi_tx_pkg;

  // Lane configuration; the raw encoding 2'b11 is folded into SINGLE on decode.
  typedef enum logic [1:0] {
    SINGLE = 2'b00,
    DUAL   = 2'b01,
    QUAD   = 2'b10
  } lane_mode_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    SHIFT     = 2'd2
  } state_e;

  // Raw command mode to lane mode; anything unrecognised behaves as single.
  function automatic lane_mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   return DUAL;
      2'b10:   return QUAD;
      default: return SINGLE;
    endcase
  endfunction

  // log2 of the lane count: bits moved per beat is 1 << lanes_shift.
  function automatic logic [1:0] lanes_shift(input lane_mode_e mode);
    case (mode)
      DUAL:    return 2'd1;
      QUAD:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Output-enable pattern for the active lanes.
  function automatic logic [3:0] lane_mask(input logic [1:0] s);
    case (s)
      2'd1:    return 4'b0011;
      2'd2:    return 4'b1111;
      default: return 4'b0001;
    endcase
  endfunction

endpackage

// File: rtl/spi_tx_shreg.sv
// Transmit shift register: parallel load, shift by the lane count in the
// selected bit order, and the lane multiplexer that drives sdo.
module spi_tx_shreg
  import spi_tx_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift,
  input  lane_mode_e        mode,
  input  logic              lsb_first,
  input  logic              out_en,
  output logic [3:0]        sdo
);

  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] shifted;
  logic [1:0]        s;

  assign s = lanes_shift(mode);

  // Next shift-register value after one beat, zero filled.
  always_comb begin
    shifted = sr;
    case (s)
      2'd2:    shifted = lsb_first ? {4'b0000, sr[DATA_W-1:4]} : {sr[DATA_W-5:0], 4'b0000};
      2'd1:    shifted = lsb_first ? {2'b00, sr[DATA_W-1:2]}   : {sr[DATA_W-3:0], 2'b00};
      default: shifted = lsb_first ? {1'b0, sr[DATA_W-1:1]}    : {sr[DATA_W-2:0], 1'b0};
    endcase
  end

  // Shift register; a reload beats a shift landing in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr <= '0;
    end else if (clr) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_data;
    end else if (shift) begin
      sr <= shifted;
    end
  end

  // Lane mux: current beat taken from the leading end of the register.
  always_comb begin
    sdo = 4'b0000;
    if (out_en) begin
      if (lsb_first) begin
        case (s)
          2'd2:    sdo      = sr[3:0];
          2'd1:    sdo[1:0] = sr[1:0];
          default: sdo[0]   = sr[0];
        endcase
      end else begin
        case (s)
          2'd2:    sdo      = sr[DATA_W-1:DATA_W-4];
          2'd1:    sdo[1:0] = sr[DATA_W-1:DATA_W-2];
          default: sdo[0]   = sr[DATA_W-1];
        endcase
      end
    end
  end

endmodule

// File: rtl/spi_master_tx_ml.sv
// Multi-lane SPI master transmit shifter. Takes a command (length, lane mode,
// bit order), pulls words from the TX FIFO and emits one beat per tx_edge.
// An empty FIFO at a word boundary stalls the SPI clock instead of sending zeros.
//
// Handshakes: a transfer happens on a clock where valid and ready are both high.
// cmd: cmd_ready depends only on state. data: data_ready is a combinational
// function of data_valid and marks the cycle in which the word is taken; the
// FIFO must not make data_ready a condition for raising data_valid.
module spi_master_tx_ml
  import spi_tx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CNT_W-1:0]  cmd_len,
  input  logic [1:0]        cmd_mode,
  input  logic              cmd_lsb_first,
  input  logic              abort,
  input  logic              tx_edge,
  input  logic [DATA_W-1:0] data,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [3:0]        sdo,
  output logic [3:0]        sdo_oe,
  output logic              tx_stall,
  output logic              tx_done,
  output logic              underrun
);

  localparam int             WC_W   = $clog2(DATA_W);
  localparam logic [CNT_W:0] BEAT_1 = (CNT_W+1)'(1);
  localparam logic [WC_W-1:0] WORD_1 = WC_W'(1);

  state_e            state, state_nx;
  lane_mode_e        mode_q;
  logic              lsb_q;
  logic [CNT_W:0]    beats_total;
  logic [CNT_W:0]    beat_cnt;
  logic [WC_W-1:0]   word_cnt;
  logic              zero_done_q;

  logic              hs;
  logic              beat_fire;
  logic              last_beat;
  logic              word_end;
  logic [1:0]        s_cmd;
  logic [1:0]        s_q;
  logic [CNT_W:0]    lanes_m1;
  logic [CNT_W:0]    beats_cmd;
  logic [WC_W-1:0]   word_last;

  assign s_cmd     = lanes_shift(decode_mode(cmd_mode));
  assign s_q       = lanes_shift(mode_q);
  // One extra bit so a maximum-length command cannot wrap when rounding up.
  assign lanes_m1  = (CNT_W+1)'((1 << s_cmd) - 1);
  assign beats_cmd = ({1'b0, cmd_len} + lanes_m1) >> s_cmd;
  assign word_last = WC_W'((DATA_W >> s_q) - 1);

  assign hs        = (state == IDLE) && cmd_valid && !abort;
  assign beat_fire = (state == SHIFT) && tx_edge && !abort;
  assign last_beat = (beat_cnt == beats_total - BEAT_1);
  assign word_end  = (word_cnt == word_last);

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next-state logic; abort overrides everything.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (hs && (cmd_len != '0)) state_nx = WAIT_DATA;
      WAIT_DATA: if (data_valid) state_nx = SHIFT;
      SHIFT: begin
        if (beat_fire) begin
          if (last_beat)                    state_nx = IDLE;
          else if (word_end && !data_valid) state_nx = WAIT_DATA;
        end
      end
      default:   state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  // FSM outputs: handshakes, stall, lane enables and event pulses.
  always_comb begin
    cmd_ready  = (state == IDLE);
    tx_stall   = (state == WAIT_DATA);
    data_ready = 1'b0;
    underrun   = 1'b0;
    tx_done    = zero_done_q && !abort;
    sdo_oe     = 4'b0000;
    case (state)
      WAIT_DATA: begin
        sdo_oe     = lane_mask(s_q);
        data_ready = data_valid && !abort;
      end
      SHIFT: begin
        sdo_oe = lane_mask(s_q);
        if (beat_fire) begin
          if (last_beat)       tx_done    = 1'b1;
          else if (word_end) begin
            if (data_valid)    data_ready = 1'b1;
            else               underrun   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Latched command config plus beat and word counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q      <= SINGLE;
      lsb_q       <= 1'b0;
      beats_total <= '0;
      beat_cnt    <= '0;
      word_cnt    <= '0;
      zero_done_q <= 1'b0;
    end else if (abort) begin
      beats_total <= '0;
      beat_cnt    <= '0;
      word_cnt    <= '0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= hs && (cmd_len == '0);
      if (hs) begin
        mode_q      <= decode_mode(cmd_mode);
        lsb_q       <= cmd_lsb_first;
        beats_total <= beats_cmd;
        beat_cnt    <= '0;
        word_cnt    <= '0;
      end else if (beat_fire) begin
        beat_cnt <= beat_cnt + BEAT_1;
        word_cnt <= word_end ? '0 : word_cnt + WORD_1;
      end else if ((state == WAIT_DATA) && data_ready) begin
        word_cnt <= '0;
      end
    end
  end

  spi_tx_shreg #(
    .DATA_W (DATA_W)
  ) u_shreg (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (abort),
    .load      (data_ready),
    .load_data (data),
    .shift     (beat_fire),
    .mode      (mode_q),
    .lsb_first (lsb_q),
    .out_en    (state != IDLE),
    .sdo       (sdo)
  );

endmodule

// File: tb/tb_spi_master_tx_ml.sv
// Directed bench for spi_master_tx_ml: one task per scenario, inline checks.
module tb_spi_master_tx_ml;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CNT_W-1:0]  cmd_len;
  logic [1:0]        cmd_mode;
  logic              cmd_lsb_first;
  logic              abort;
  logic              tx_edge;
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              data_ready;
  logic [3:0]        sdo;
  logic [3:0]        sdo_oe;
  logic              tx_stall;
  logic              tx_done;
  logic              underrun;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_cnt  = 0;
  int done_cnt = 0;
  int und_cnt  = 0;

  spi_master_tx_ml #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_len       (cmd_len),
    .cmd_mode      (cmd_mode),
    .cmd_lsb_first (cmd_lsb_first),
    .abort         (abort),
    .tx_edge       (tx_edge),
    .data          (data),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .sdo           (sdo),
    .sdo_oe        (sdo_oe),
    .tx_stall      (tx_stall),
    .tx_done       (tx_done),
    .underrun      (underrun)
  );

  // clock / reset
  always #5 clk = ~clk;

  // pulse counters, sampled mid low phase
  always begin
    @(negedge clk);
    #2;
    if (data_ready === 1'b1) rdy_cnt++;
    if (tx_done === 1'b1)    done_cnt++;
    if (underrun === 1'b1)   und_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic start_cmd(input logic [CNT_W-1:0] len, input logic [1:0] mode,
                           input logic lsb, output logic rdy);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_len = len; cmd_mode = mode; cmd_lsb_first = lsb;
    #1 rdy = cmd_ready;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_len = ~len; cmd_mode = ~mode; cmd_lsb_first = ~lsb;
  endtask

  task automatic feed_word(input logic [DATA_W-1:0] w, output logic r, output logic st);
    @(negedge clk);
    data = w; data_valid = 1'b1;
    #1 r = data_ready; st = tx_stall;
    @(posedge clk);
    #1 data_valid = 1'b0;
  endtask

  task automatic beat(output logic [3:0] s, output logic [3:0] oe, output logic d,
                      output logic r, output logic u, output logic st);
    @(negedge clk);
    tx_edge = 1'b1;
    #1 s = sdo; oe = sdo_oe; d = tx_done; r = data_ready; u = underrun; st = tx_stall;
    @(posedge clk);
    #1 tx_edge = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0; cmd_valid = 0; cmd_len = '0; cmd_mode = 0; cmd_lsb_first = 0;
    abort = 0; tx_edge = 0; data = '0; data_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({sdo, sdo_oe, tx_stall, tx_done, underrun, data_ready} !== 12'h000) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 000", {sdo, sdo_oe, tx_stall, tx_done, underrun, data_ready});
    end
    @(negedge clk) rstn = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_single_msb();
    logic r, st, d, u; logic [3:0] s, oe; logic [31:0] rx = '0; int done_at = -1; int bad = 0;
    rdy_cnt = 0; done_cnt = 0;
    start_cmd(16'd32, 2'b00, 1'b0, r);
    n_checks++;
    if (r !== 1'b1) begin n_fail++; $display("FAIL single_cmd_ready: got %b want 1", r); end
    feed_word(32'hA5A5_0F0F, r, st);
    n_checks++;
    if ({r, st} !== 2'b11) begin n_fail++; $display("FAIL single_load: ready/stall got %b want 11", {r, st}); end
    for (int i = 0; i < 32; i++) begin
      beat(s, oe, d, r, u, st);
      rx = {rx[30:0], s[0]};
      if (d) done_at = i;
      if (oe !== 4'b0001 || s[3:1] !== 3'b000 || st !== 1'b0) bad++;
    end
    n_checks++;
    if (rx !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL single_bits: got %h want a5a50f0f", rx); end
    n_checks++;
    if (done_at !== 31) begin n_fail++; $display("FAIL single_done_edge: got %0d want 31", done_at); end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL single_lanes: bad beats got %0d want 0", bad); end
    n_checks++;
    if ({rdy_cnt, done_cnt} !== {32'd1, 32'd1}) begin
      n_fail++; $display("FAIL single_pulses: ready %0d done %0d want 1 1", rdy_cnt, done_cnt);
    end
    n_checks++;
    if ({cmd_ready, sdo_oe, sdo} !== 9'h100) begin
      n_fail++; $display("FAIL single_idle: got %h want 100", {cmd_ready, sdo_oe, sdo});
    end
  endtask

  task automatic test_back_to_back();
    logic r, st, d, u; logic [3:0] s, oe; logic [63:0] rx = '0; int done_at = -1; logic rel = 0;
    rdy_cnt = 0; done_cnt = 0; und_cnt = 0;
    start_cmd(16'd64, 2'b10, 1'b0, r);
    feed_word(32'h1234_5678, r, st);
    for (int i = 0; i < 16; i++) begin
      if (i == 7) begin data = 32'h9ABC_DEF0; data_valid = 1'b1; end
      beat(s, oe, d, r, u, st);
      if (i == 7) begin data_valid = 1'b0; rel = r && !st && !u; end
      rx = {rx[59:0], s};
      if (d) done_at = i;
    end
    n_checks++;
    if (rx !== 64'h1234_5678_9ABC_DEF0) begin n_fail++; $display("FAIL quad_nibbles: got %h want 123456789abcdef0", rx); end
    n_checks++;
    if (rel !== 1'b1) begin n_fail++; $display("FAIL quad_reload_edge8: got %b want 1", rel); end
    n_checks++;
    if (done_at !== 15) begin n_fail++; $display("FAIL quad_done_edge: got %0d want 15", done_at); end
    n_checks++;
    if ({rdy_cnt, und_cnt} !== {32'd2, 32'd0}) begin
      n_fail++; $display("FAIL quad_pulses: ready %0d underrun %0d want 2 0", rdy_cnt, und_cnt);
    end
  endtask

  task automatic test_dual_lsb();
    logic r, st, d, u; logic [3:0] s, oe; int done_at = -1; int bad_oe = 0;
    logic [1:0] exp_p [5] = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b10};
    start_cmd(16'd10, 2'b01, 1'b1, r);
    feed_word(32'h0000_02D5, r, st);
    for (int i = 0; i < 5; i++) begin
      beat(s, oe, d, r, u, st);
      n_checks++;
      if (s !== {2'b00, exp_p[i]}) begin n_fail++; $display("FAIL dual_beat%0d: got %b want %b", i, s, {2'b00, exp_p[i]}); end
      if (oe !== 4'b0011) bad_oe++;
      if (d) done_at = i;
    end
    n_checks++;
    if (bad_oe !== 0) begin n_fail++; $display("FAIL dual_oe: bad beats got %0d want 0", bad_oe); end
    n_checks++;
    if (done_at !== 4) begin n_fail++; $display("FAIL dual_done_edge: got %0d want 4", done_at); end
  endtask

  task automatic test_underrun();
    logic r, st, d, u; logic [3:0] s, oe; logic [63:0] rx = '0; int done_at = -1; int bad = 0; logic und8 = 0;
    rdy_cnt = 0; und_cnt = 0;
    start_cmd(16'd64, 2'b10, 1'b0, r);
    feed_word(32'h1234_5678, r, st);
    for (int i = 0; i < 8; i++) begin
      beat(s, oe, d, r, u, st);
      rx = {rx[59:0], s};
      if (i == 7) und8 = u && !r;
    end
    n_checks++;
    if (und8 !== 1'b1) begin n_fail++; $display("FAIL underrun_edge8: got %b want 1", und8); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1 if (tx_stall !== 1'b1 || sdo_oe !== 4'b1111) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL underrun_stall: bad cycles got %0d want 0", bad); end
    feed_word(32'h9ABC_DEF0, r, st);
    n_checks++;
    if ({r, st} !== 2'b11) begin n_fail++; $display("FAIL underrun_resume: ready/stall got %b want 11", {r, st}); end
    for (int i = 8; i < 16; i++) begin
      beat(s, oe, d, r, u, st);
      rx = {rx[59:0], s};
      if (d) done_at = i;
    end
    n_checks++;
    if (rx !== 64'h1234_5678_9ABC_DEF0) begin n_fail++; $display("FAIL underrun_nibbles: got %h want 123456789abcdef0", rx); end
    n_checks++;
    if (done_at !== 15) begin n_fail++; $display("FAIL underrun_done_edge: got %0d want 15", done_at); end
    n_checks++;
    if ({rdy_cnt, und_cnt} !== {32'd2, 32'd1}) begin
      n_fail++; $display("FAIL underrun_pulses: ready %0d underrun %0d want 2 1", rdy_cnt, und_cnt);
    end
  endtask

  task automatic test_zero_len_and_mode3();
    logic r, st, d, u; logic [3:0] s, oe; logic [7:0] rx = '0; int done_at = -1; int bad = 0;
    rdy_cnt = 0; done_cnt = 0;
    data = 32'hFFFF_FFFF; data_valid = 1'b1;
    start_cmd(16'd0, 2'b00, 1'b0, r);
    #1;
    n_checks++;
    if ({tx_done, cmd_ready} !== 2'b11) begin n_fail++; $display("FAIL zero_done: done/ready got %b want 11", {tx_done, cmd_ready}); end
    @(posedge clk);
    #2;
    n_checks++;
    if (tx_done !== 1'b0) begin n_fail++; $display("FAIL zero_done_width: got %b want 0", tx_done); end
    data_valid = 1'b0;
    n_checks++;
    if ({rdy_cnt, done_cnt} !== {32'd0, 32'd1}) begin
      n_fail++; $display("FAIL zero_pulses: ready %0d done %0d want 0 1", rdy_cnt, done_cnt);
    end
    start_cmd(16'd8, 2'b11, 1'b0, r);
    feed_word(32'h9600_0000, r, st);
    for (int i = 0; i < 8; i++) begin
      beat(s, oe, d, r, u, st);
      rx = {rx[6:0], s[0]};
      if (oe !== 4'b0001 || s[3:1] !== 3'b000) bad++;
      if (d) done_at = i;
    end
    n_checks++;
    if (rx !== 8'h96) begin n_fail++; $display("FAIL mode3_bits: got %h want 96", rx); end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL mode3_lanes: bad beats got %0d want 0", bad); end
    n_checks++;
    if (done_at !== 7) begin n_fail++; $display("FAIL mode3_done_edge: got %0d want 7", done_at); end
  endtask

  task automatic test_abort();
    logic r, st, d, u; logic [3:0] s, oe;
    done_cnt = 0; rdy_cnt = 0;
    start_cmd(16'd6, 2'b00, 1'b0, r);
    feed_word(32'hFFFF_FFFF, r, st);
    for (int i = 0; i < 5; i++) beat(s, oe, d, r, u, st);
    @(negedge clk);
    abort = 1'b1; tx_edge = 1'b1;
    #1;
    n_checks++;
    if (tx_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b want 0", tx_done); end
    @(posedge clk);
    #1 abort = 1'b0; tx_edge = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({cmd_ready, sdo_oe, sdo, tx_stall} !== 10'h200) begin
      n_fail++; $display("FAIL abort_idle: got %h want 200", {cmd_ready, sdo_oe, sdo, tx_stall});
    end
    start_cmd(16'd32, 2'b10, 1'b0, r);
    @(negedge clk);
    abort = 1'b1; data = 32'h1111_1111; data_valid = 1'b1;
    #1;
    n_checks++;
    if (data_ready !== 1'b0) begin n_fail++; $display("FAIL abort_no_ready: got %b want 0", data_ready); end
    @(posedge clk);
    #1 abort = 1'b0; data_valid = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready, sdo_oe, tx_stall} !== 6'h20) begin
      n_fail++; $display("FAIL abort_wait_idle: got %h want 20", {cmd_ready, sdo_oe, tx_stall});
    end
    n_checks++;
    if ({done_cnt, rdy_cnt} !== {32'd0, 32'd1}) begin
      n_fail++; $display("FAIL abort_pulses: done %0d ready %0d want 0 1", done_cnt, rdy_cnt);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic r, st, d, u; logic [3:0] s, oe;
    start_cmd(16'd64, 2'b10, 1'b0, r);
    feed_word(32'h1234_5678, r, st);
    for (int i = 0; i < 3; i++) beat(s, oe, d, r, u, st);
    @(negedge clk);
    data_valid = 1'b1; tx_edge = 1'b1;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({sdo, sdo_oe, tx_stall, tx_done, underrun, data_ready} !== 12'h000) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %h want 000", {sdo, sdo_oe, tx_stall, tx_done, underrun, data_ready});
    end
    data_valid = 1'b0; tx_edge = 1'b0;
    @(negedge clk) rstn = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_msb();
    test_back_to_back();
    test_dual_lsb();
    test_underrun();
    test_zero_len_and_mode3();
    test_abort();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_tx_ml.md
Name: spi_master_tx_ml

Overview:
- Parametrised multi-lane SPI master transmit shifter. Supports single, dual and quad lanes, MSB- or LSB-first order and a configurable word width.
- Underrun handling stalls the SPI clock rather than shifting zeros.
- Sits between the TX FIFO (valid/ready word stream) and the SPI clock generator. It consumes one tx_edge per beat and reports completion, stall and underrun to the controller FSM.

Parameters:
- DATA_W, 32, word width from the FIFO. Multiple of 4, ≥8.
- CNT_W, 16, width of the transfer length in bits.

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- cmd_valid  in  1  start request
- cmd_ready  out  1  high in IDLE only
- cmd_len  in  CNT_W  transfer length in bits; latched on cmd handshake
- cmd_mode  in  2  00 single, 01 dual, 10 quad, 11 treated as single; latched
- cmd_lsb_first  in  1  bit order; latched
- abort  in  1  synchronous abort
- tx_edge  in  1  one-cycle beat strobe from the clock generator
- data  in  DATA_W  word from the FIFO
- data_valid  in  1  FIFO word available
- data_ready  out  1  word consumed this cycle
- sdo  out  4  serial data lanes
- sdo_oe  out  4  per-lane output enable
- tx_stall  out  1  clock generator must suppress edges
- tx_done  out  1  one-cycle pulse on the final beat
- underrun  out  1  one-cycle pulse when the FIFO is empty at a word boundary

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE; shift register, counters and latched config cleared.
  - sdo=0, sdo_oe=0, tx_stall=0, tx_done=0, underrun=0, data_ready=0.
  - cmd_ready=1 after reset releases.
- Lanes L = 1/2/4 per mode; shift amount s = 0/1/2.
- Beat target, computed on the cmd handshake in CNT_W+1 bits (no overflow at cmd_len = 2^CNT_W−1):
  - beats_total = (cmd_len + L − 1) >> s.
  - A partial final beat transmits stale/zero bits on the unused lanes.
- Beats per word = DATA_W >> s. The word beat counter has width clog2(DATA_W).
- States:
  - IDLE: cmd_ready=1.
    - cmd_valid with cmd_len=0 → tx_done pulses next cycle; stay IDLE.
    - cmd_valid with cmd_len≠0 → WAIT_DATA.
  - WAIT_DATA: tx_stall=1; data_ready = data_valid (combinational).
    - On data_valid: load the shift register, reset the word beat counter → SHIFT.
  - SHIFT: on tx_edge, increment the beat counter and shift by L bits (left if MSB-first, right if LSB-first; zero fill).
    - If the beat just sent is beat beats_total−1: tx_done=1 in the same cycle → IDLE.
    - Else if it was the last beat of the word and data_valid=1: data_ready=1 the same cycle, reload with no bubble, stay SHIFT.
    - Else if it was the last beat of the word and data_valid=0: underrun=1 → WAIT_DATA.
    - No tx_edge → hold all state.
- Lane mapping, current beat visible from the load until the next tx_edge:
  - MSB-first: quad sdo[3:0]=sr[DATA_W−1:DATA_W−4]; dual sdo[1:0]=sr[DATA_W−1:DATA_W−2]; single sdo[0]=sr[DATA_W−1].
  - LSB-first: sdo[L−1:0]=sr[L−1:0].
  - Unused lanes = 0.
- sdo_oe: bits [L−1:0] = 1 in WAIT_DATA and SHIFT; 0 in IDLE.
- abort: highest priority after reset. Next cycle → IDLE with counters cleared; no tx_done, no data_ready that cycle.
- Simultaneous tx_edge and FIFO reload: reload wins over the zero-fill shift.
- Config inputs are ignored outside the cmd handshake. Mid-transfer changes have no effect.

Decomposition:
- Package spi_tx_pkg:
  - lane_mode_e enum (SINGLE, DUAL, QUAD).
  - state_e enum (IDLE, WAIT_DATA, SHIFT).
  - function lanes_shift(mode) returning s.
- One sub-module, spi_tx_shreg:
  - DATA_W shift register with load, shift-by-L and direction.
  - Lane output mux driving sdo.
- The top level holds the FSM, counters and handshakes.

Test Plan:
- Single, MSB-first, cmd_len=32, data=0xA5A5_0F0F, tx_edge every 4 clk → sdo[0] sequence 1,0,1,0,0,1,0,1,…,1,1,1,1; tx_done on the 32nd edge; data_ready exactly once.
- Quad, MSB-first, cmd_len=64, words 0x1234_5678 then 0x9ABC_DEF0 back-to-back → nibbles 1..8,9..0 over 16 edges; reload on edge 8 with no stall; tx_done on edge 16.
- Dual, LSB-first, cmd_len=10, data=0x0000_02D5 → sdo[1:0] sequence 01,01,01,11,10; tx_done on edge 5; sdo_oe=0011.
- Quad, cmd_len=64, second word delayed 20 clk → underrun pulse on edge 8, tx_stall=1 for the whole wait; resumes with 0x9…; tx_done on edge 16.
- cmd_len=0 → tx_done 1 cycle after the handshake; no data_ready. Mode 11 with cmd_len=8 → behaves as single.
- abort after 5 edges → IDLE next cycle, sdo_oe=0, no tx_done. rstn pulse mid-SHIFT → all outputs 0 immediately.
